// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue,
// cleared by write-back, reduced to a single stall for the two read ports.
// Optional feature: REGFILE_BYPASS_EN masks a port's busy contribution when
// the same-cycle write targets that port's address.
module reg_scoreboard
#(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              load_issue,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              stall
);
  import regfile_pkg::*;

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_hit;
  logic            load_hit;
  logic            byp1;
  logic            byp2;

  assign wr_hit   = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
  assign load_hit = load_issue && (load_addr != ADDR_W'(ZERO_REG));

  // Next busy vector: clear on write-back, then set on issue so a new load wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (load_hit) begin
      busy_d[load_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy register; reset discards all pending loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A write landing this cycle satisfies the port reading that register.
  assign byp1 = wr_hit && (wr_addr == rd_addr1);
  assign byp2 = wr_hit && (wr_addr == rd_addr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Stall when either port targets a register still waiting for its load.
  always_comb begin
    stall = (busy_q[rd_addr1] && !byp1) || (busy_q[rd_addr2] && !byp2);
  end

endmodule

// File: rtl/register_file.sv
// MIPS integer register file: 2**ADDR_W x WIDTH storage, two combinational
// read ports, one synchronous write port, r0 hardwired to zero, plus a
// pending-load scoreboard driving Stall.
// Optional feature: REGFILE_BYPASS_EN forwards same-cycle write data to a
// matching read port.
module register_file
#(
  parameter int unsigned WIDTH  = regfile_pkg::WIDTH,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RdAddr1,
  input  logic [ADDR_W-1:0] RdAddr2,
  output logic [WIDTH-1:0]  RdData1,
  output logic [WIDTH-1:0]  RdData2,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              LoadIssue,
  input  logic [ADDR_W-1:0] LoadAddr,
  output logic              Stall
);
  import regfile_pkg::*;

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [NREG];
  logic             wr_hit;

  assign wr_hit = WrEn && (WrAddr != ADDR_W'(ZERO_REG));

  // Storage array; entry 0 is never written so it always holds zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  // Read port 1; output forced to zero while reset is held.
  always_comb begin
    RdData1 = '0;
    if (Rst_n && (RdAddr1 != ADDR_W'(ZERO_REG))) begin
      RdData1 = mem_q[RdAddr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (WrAddr == RdAddr1)) begin
        RdData1 = WrData;
      end
`endif
    end
  end

  // Read port 2; output forced to zero while reset is held.
  always_comb begin
    RdData2 = '0;
    if (Rst_n && (RdAddr2 != ADDR_W'(ZERO_REG))) begin
      RdData2 = mem_q[RdAddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (WrAddr == RdAddr2)) begin
        RdData2 = WrData;
      end
`endif
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .rd_addr1   (RdAddr1),
    .rd_addr2   (RdAddr2),
    .wr_en      (WrEn),
    .wr_addr    (WrAddr),
    .load_issue (LoadIssue),
    .load_addr  (LoadAddr),
    .stall      (Stall)
  );

endmodule
